niosii_niosii_oci_dct_packer: RTL and testbench
===============================================

// Module: niosii_NIOSII_oci_dct_packer
// PURPOSE
//  Sequences the OCI data-compressed-trace (DCT) datapath: packs 2-bit trace atoms into the
//  30-bit dct_buffer, tracks dct_count, and hands full or flushed words to trace memory
//  over a valid/ready handshake. Sits between the CPU trace-atom source and the OCI trace RAM
//  writer. Its dct_buffer/dct_count are the signals the OCI test bench monitors.
// PARAMETERS
//  ATOM_W   2   bits per trace atom
//  DEPTH    15  atoms per packed word (BUF_W = ATOM_W*DEPTH = 30)
//  CNT_W    4   width of atom counter; must hold DEPTH
// PORTS
//  clk          in   1      system clock, all logic rising-edge
//  reset_n      in   1      asynchronous active-low reset
//  atom_valid   in   1      trace atom present this cycle (no backpressure; drop on overflow)
//  atom         in   2      trace atom payload
//  flush        in   1      1-cycle pulse: emit partial word as soon as possible
//  clr_overflow in   1      clears sticky overflow
//  trc_ready    in   1      trace RAM writer accepts trc_data this cycle
//  trc_valid    out  1      packed word available
//  trc_data     out  30     packed word, atoms right-aligned, newest in [1:0]
//  trc_count    out  4      atoms in trc_data (1..15)
//  dct_buffer   out  30     live packing buffer
//  dct_count    out  4      atoms currently in dct_buffer (0..15)
//  overflow     out  1      sticky: >=1 atom dropped
//  busy         out  1      dct_count!=0 | trc_valid | flush_pend
// BEHAVIOUR
//  Reset: all outputs 0, flush_pend 0, state EMPTY; in-flight word discarded (mid-op too).
//  Accept: atom_valid & state!=HOLD -> dct_buffer <= {dct_buffer[27:0],atom}; dct_count+1.
//  slot_free = ~trc_valid | trc_ready (output register empty or drained this cycle).
//  FSM (registered dct_count drives it):
//   EMPTY: count==0. accept -> FILL. flush ignored (nothing to send).
//   FILL : 1..14 atoms. Accept of 15th atom -> HOLD. flush -> flush_pend<=1, -> HOLD
//          (an atom accepted the same cycle as flush is included in the word).
//   HOLD : buffer frozen (count 15, or partial with flush_pend). If slot_free: transfer
//          trc_data<=dct_buffer, trc_count<=dct_count, trc_valid<=1, flush_pend<=0;
//          same cycle an incoming atom becomes buffer atom 0 (dct_buffer<={28'b0,atom},
//          dct_count<=1, -> FILL), else buffer/count clear, -> EMPTY.
//          If ~slot_free: atom_valid dropped, overflow<=1, stay HOLD.
//  Latency: 15th atom accepted at edge N -> trc_valid high after edge N+1 if slot free.
//  Handshake: trc_valid held, trc_data/trc_count stable until sampled with trc_ready.
//   trc_valid&trc_ready with no new transfer -> trc_valid<=0 next edge. Back-to-back words
//   allowed (transfer and drain in same cycle keep trc_valid=1).
//  Unused upper buffer bits are 0 (partial words zero-filled above atom count).
//  overflow: set on any dropped atom; clr_overflow clears; set wins over simultaneous clear.
//  flush while HOLD: no extra effect (word already pending). flush in EMPTY: no word.
//  Count arithmetic is unsigned CNT_W; never exceeds DEPTH (no wrap).
// TESTING
//  1 15 atoms 0,1,2,3,0.. back-to-back, trc_ready=1 -> one word, trc_count=15,
//    trc_data[1:0]=atom15, trc_valid 1 cycle, dct_count returns 0, overflow=0.
//  2 3 atoms (1,2,3) then flush, trc_ready=1 -> trc_data=30'h1B, trc_count=3, busy drops.
//  3 30 atoms continuous, trc_ready=1 -> two words of count 15, no drop, 16th atom in
//    new buffer during transfer cycle.
//  4 trc_ready=0, 35 atoms -> word 1 held stable, buffer fills to 15, remaining atoms
//    dropped, overflow=1; release ready -> word1 then word2, clr_overflow -> 0.
//  5 flush with count=0 -> no trc_valid; flush+atom same cycle in FILL -> atom included.
//  6 reset_n low mid-fill (count=7) and with trc_valid=1 -> all outputs 0 immediately,
//    no word after release; next 15 atoms produce normal word.

Source files
------------

// File: rtl/niosii_niosii_oci_dct_packer.sv
// Packs 2-bit trace atoms into a 30-bit word and hands full or flushed words
// to the trace RAM writer over a valid/ready handshake.
module niosii_niosii_oci_dct_packer #(
  parameter int unsigned ATOM_W = 2,
  parameter int unsigned DEPTH  = 15,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      atom_valid,
  input  logic [ATOM_W-1:0]         atom,
  input  logic                      flush,
  input  logic                      clr_overflow,
  input  logic                      trc_ready,
  output logic                      trc_valid,
  output logic [ATOM_W*DEPTH-1:0]   trc_data,
  output logic [CNT_W-1:0]          trc_count,
  output logic [ATOM_W*DEPTH-1:0]   dct_buffer,
  output logic [CNT_W-1:0]          dct_count,
  output logic                      overflow,
  output logic                      busy
);

  localparam int unsigned BUF_W = ATOM_W * DEPTH;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t             state, state_n;
  logic               flush_pend, pend_n;
  logic [BUF_W-1:0]   buf_n, td_n, shifted;
  logic [CNT_W-1:0]   cnt_n, tc_n;
  logic               tv_n, ovf_n, busy_n;
  logic               slot_free;

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_EMPTY;
      flush_pend <= 1'b0;
      dct_buffer <= '0;
      dct_count  <= '0;
      trc_valid  <= 1'b0;
      trc_data   <= '0;
      trc_count  <= '0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      flush_pend <= pend_n;
      dct_buffer <= buf_n;
      dct_count  <= cnt_n;
      trc_valid  <= tv_n;
      trc_data   <= td_n;
      trc_count  <= tc_n;
      overflow   <= ovf_n;
      busy       <= busy_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    pend_n    = flush_pend;
    buf_n     = dct_buffer;
    cnt_n     = dct_count;
    tv_n      = trc_valid;
    td_n      = trc_data;
    tc_n      = trc_count;
    ovf_n     = overflow & ~clr_overflow;
    slot_free = ~trc_valid | trc_ready;
    shifted   = {dct_buffer[BUF_W-ATOM_W-1:0], atom};

    if (trc_valid && trc_ready) tv_n = 1'b0;

    unique case (state)
      ST_EMPTY: begin
        if (atom_valid) begin
          buf_n   = BUF_W'(atom);
          cnt_n   = CNT_W'(1);
          state_n = ST_FILL;
        end
      end
      ST_FILL: begin
        if (atom_valid) begin
          buf_n = shifted;
          cnt_n = dct_count + CNT_W'(1);
          if (dct_count == CNT_W'(DEPTH - 1)) state_n = ST_HOLD;
        end
        // A same-cycle atom is already in buf_n, so the flushed word includes it
        if (flush) begin
          pend_n  = 1'b1;
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (slot_free) begin
          tv_n   = 1'b1;
          td_n   = dct_buffer;
          tc_n   = dct_count;
          pend_n = 1'b0;
          if (atom_valid) begin
            buf_n   = BUF_W'(atom);
            cnt_n   = CNT_W'(1);
            state_n = ST_FILL;
          end else begin
            buf_n   = '0;
            cnt_n   = '0;
            state_n = ST_EMPTY;
          end
        end else if (atom_valid) begin
          ovf_n = 1'b1;
        end
      end
      default: begin
        state_n = ST_EMPTY;
        pend_n  = 1'b0;
        buf_n   = '0;
        cnt_n   = '0;
      end
    endcase

    busy_n = (cnt_n != '0) | tv_n | pend_n;
  end

endmodule

// File: tb/tb_niosii_niosii_oci_dct_packer.sv
// Directed bench for the DCT packer: a per-cycle vector table for short
// sequences plus hand-written multi-cycle scenarios.
module tb_niosii_niosii_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        atom_valid;
  logic [1:0]  atom;
  logic        flush;
  logic        clr_overflow;
  logic        trc_ready;
  logic        trc_valid;
  logic [29:0] trc_data;
  logic [3:0]  trc_count;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;
  logic        busy;

  int errors = 0;
  int checks = 0;

  localparam logic [29:0] WORD_A = 30'h06C6C6C6; // atoms i%4, i=0..14
  localparam logic [29:0] WORD_B = 30'h31B1B1B1; // atoms i%4, i=15..29

  niosii_niosii_oci_dct_packer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .atom_valid   (atom_valid),
    .atom         (atom),
    .flush        (flush),
    .clr_overflow (clr_overflow),
    .trc_ready    (trc_ready),
    .trc_valid    (trc_valid),
    .trc_data     (trc_data),
    .trc_count    (trc_count),
    .dct_buffer   (dct_buffer),
    .dct_count    (dct_count),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [1:0]  a;
    logic        fl;
    logic        clr;
    logic        rdy;
    logic        e_valid;
    logic [29:0] e_data;
    logic [3:0]  e_tcnt;
    logic [29:0] e_buf;
    logic [3:0]  e_dcnt;
    logic        e_ovf;
    logic        e_busy;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [1:0] a, input logic fl, input logic clr, input logic rdy);
    atom_valid   = av;
    atom         = a;
    flush        = fl;
    clr_overflow = clr;
    trc_ready    = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    check("reset_outputs", 0,
          64'({trc_valid, trc_data, trc_count, dct_buffer, dct_count, overflow, busy}), 64'd0);
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    logic        stable;
    // {av,a,fl,clr,rdy, e_valid,e_data,e_tcnt, e_buf,e_dcnt,e_ovf,e_busy}
    vecs[0]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 30'h0,  4'd0, 30'h1,  4'd1, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 30'h0,  4'd0, 30'h6,  4'd2, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 30'h0,  4'd0, 30'h1B, 4'd3, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 30'h0,  4'd0, 30'h1B, 4'd3, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 30'h1B, 4'd3, 30'h0,  4'd0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 30'h0,  4'd0, 30'h0,  4'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 30'h0,  4'd0, 30'h0,  4'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 30'h0,  4'd0, 30'h2,  4'd1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 30'h0,  4'd0, 30'h9,  4'd2, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 30'h9,  4'd2, 30'h3,  4'd1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 30'h9,  4'd2, 30'h3,  4'd1, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 30'h9,  4'd2, 30'h3,  4'd1, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 30'h9,  4'd2, 30'h3,  4'd1, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 30'h9,  4'd2, 30'h3,  4'd1, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 30'h3,  4'd1, 30'h0,  4'd0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 30'h0,  4'd0, 30'h0,  4'd0, 1'b0, 1'b0};

    do_reset();

    // Partial word via flush, flush when empty, flush with same-cycle atom, overflow set/clear
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].av, vecs[i].a, vecs[i].fl, vecs[i].clr, vecs[i].rdy);
      tick();
      check("vec_state", i, 64'({trc_valid, dct_count, dct_buffer, overflow, busy}),
            64'({vecs[i].e_valid, vecs[i].e_dcnt, vecs[i].e_buf, vecs[i].e_ovf, vecs[i].e_busy}));
      if (vecs[i].e_valid)
        check("vec_word", i, 64'({trc_data, trc_count}), 64'({vecs[i].e_data, vecs[i].e_tcnt}));
    end

    // 15 atoms back-to-back: one full word, one cycle of trc_valid
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 2'(i % 4), 1'b0, 1'b0, 1'b1);
      tick();
    end
    check("full_buf", 0, 64'({trc_valid, dct_count, dct_buffer}), 64'({1'b0, 4'd15, WORD_A}));
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check("full_word", 0, 64'({trc_valid, trc_count, trc_data, dct_count}),
          64'({1'b1, 4'd15, WORD_A, 4'd0}));
    check("full_lsb_atom", 0, 64'(trc_data[1:0]), 64'd2);
    tick();
    check("full_drain", 0, 64'({trc_valid, overflow, busy}), 64'd0);

    // 30 atoms continuous: 16th atom enters the new buffer during the transfer cycle
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, 2'(i % 4), 1'b0, 1'b0, 1'b1);
      tick();
      if (i == 15)
        check("b2b_word1", 0, 64'({trc_valid, trc_count, trc_data, dct_count, dct_buffer}),
              64'({1'b1, 4'd15, WORD_A, 4'd1, 30'h3}));
      if (i == 16)
        check("b2b_drain1", 0, 64'({trc_valid, dct_count}), 64'({1'b0, 4'd2}));
    end
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check("b2b_word2", 0, 64'({trc_valid, trc_count, trc_data, overflow}),
          64'({1'b1, 4'd15, WORD_B, 1'b0}));
    tick();
    check("b2b_drain2", 0, 64'({trc_valid, busy}), 64'd0);

    // Stalled writer: word 1 held, buffer fills, extra atoms dropped
    stable = 1'b1;
    for (int i = 0; i < 35; i++) begin
      drive(1'b1, 2'(i % 4), 1'b0, 1'b0, 1'b0);
      tick();
      if (i >= 15 && (trc_valid !== 1'b1 || trc_data !== WORD_A || trc_count !== 4'd15))
        stable = 1'b0;
    end
    check("stall_stable", 0, 64'(stable), 64'd1);
    check("stall_state", 0, 64'({trc_valid, trc_data, dct_count, dct_buffer, overflow}),
          64'({1'b1, WORD_A, 4'd15, WORD_B, 1'b1}));
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check("stall_word2", 0, 64'({trc_valid, trc_count, trc_data, dct_count}),
          64'({1'b1, 4'd15, WORD_B, 4'd0}));
    tick();
    check("stall_drain", 0, 64'({trc_valid, overflow}), 64'({1'b0, 1'b1}));
    drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    tick();
    check("stall_clr", 0, 64'({overflow, busy}), 64'd0);

    // Reset mid-fill
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
      tick();
    end
    check("mid_fill_cnt", 0, 64'(dct_count), 64'd7);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_idle", i, 64'({trc_valid, dct_count, busy}), 64'd0);
    end

    // Reset while a word is pending in the output register
    for (int i = 0; i < 16; i++) begin
      drive(i < 15, 2'(i % 4), 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("pend_valid", 0, 64'({trc_valid, trc_data}), 64'({1'b1, WORD_A}));
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_valid", i, 64'({trc_valid, busy}), 64'd0);
    end

    // Normal word after reset
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 2'(i % 4), 1'b0, 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check("after_rst_word", 0, 64'({trc_valid, trc_count, trc_data}),
          64'({1'b1, 4'd15, WORD_A}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
